fire_weight_fetch: RTL and testbench
====================================

FIRE_WEIGHT_FETCH -- requirements
Module: fire_weight_fetch

Interface
REQ-001 Parameter WIDTH, default 16, bits per weight word.
REQ-002 Parameter ADDR, default 4, weight ROM address width.
REQ-003 Parameter NUM, default 64, weight words per ROM row (one per output filter).
REQ-004 Parameter DEPTH, default 2**ADDR, rows fetched per pass; legal range 1..2**ADDR.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request one fetch pass; sampled only in IDLE.
REQ-008 rom_addr  output  ADDR  row address driven to the combinational weight ROM.
REQ-009 rom_data  input  WIDTH x NUM (unpacked [0:NUM-1])  ROM row at rom_addr, valid in the same cycle.
REQ-010 w_valid  output  1  w_data/w_index/w_last hold a row.
REQ-011 w_ready  input  1  MAC array accepts the row.
REQ-012 w_data  output  WIDTH x NUM (unpacked [0:NUM-1])  registered weight row.
REQ-013 w_index  output  ADDR  row number of w_data.
REQ-014 w_last  output  1  w_data is row DEPTH-1 of the pass.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at pass completion.

Function
REQ-017 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start; FETCH->DRAIN after row DEPTH-1 is captured; DRAIN->DONE on the beat where w_valid && w_ready && w_last; DONE->IDLE unconditionally after one cycle.
REQ-018 Beat = cycle with w_valid && w_ready; the output register loads when (!w_valid || w_ready) in FETCH.
REQ-019 rom_addr holds an internal row counter; counter resets to 0 on IDLE->FETCH and increments only on a cycle where the output register loads in FETCH.
REQ-020 Latency: start high in IDLE at cycle N -> rom_addr=0 at N+1 -> w_valid=1, w_index=0 at N+2.
REQ-021 Throughput: with w_ready held high, one row per cycle, rows 0..DEPTH-1 in order, no gaps.
REQ-022 Backpressure: while w_valid && !w_ready, w_data, w_index, w_last and rom_addr remain stable.
REQ-023 w_valid falls the cycle after the last beat unless a new row loads in the same cycle.
REQ-024 done pulses in the DONE cycle, exactly one cycle after the beat carrying w_last.
REQ-025 start in any state other than IDLE is ignored and not queued.
REQ-026 DEPTH=1: the single row carries w_last=1 and w_index=0.
REQ-027 rom_addr is 0 in IDLE and DONE; counter never exceeds DEPTH-1 (no wrap).

Reset
REQ-028 rst high at any clock edge, including mid-pass or under backpressure, forces IDLE, counter=0, rom_addr=0, w_valid=0, w_last=0, w_index=0, busy=0, done=0; w_data is cleared to 0.
REQ-029 The first start is honoured on the first clock after rst deasserts.

Configuration
REQ-030 Macro WFETCH_LOOP_EN: when defined, adds input loop_cnt (8 bits), sampled at start; the pass repeats loop_cnt+1 times back-to-back, with no bubble between row DEPTH-1 and the next row 0; w_last is asserted only on the final pass; done pulses once.
REQ-031 Without WFETCH_LOOP_EN, the loop_cnt port is absent and exactly one pass runs per start.

Structure
REQ-032 Package fire_wfetch_pkg holds the FSM state enum and default WIDTH/NUM constants shared with the ROM and MAC blocks.
REQ-033 Single module: no sub-module; the ROM is instantiated by the parent alongside this block.

Verification
REQ-034 Reset, then start=1 for 1 cycle, w_ready=1, DEPTH=16, ROM row k word j = k*64+j -> 16 consecutive beats, w_index 0..15, w_data[5] at index 3 = 197, w_last on index 15, done one cycle later.
REQ-035 w_ready low for 3 cycles when w_index=7 -> w_data, w_index=7 and rom_addr held stable; the sequence resumes with index 8; no row is lost or duplicated.
REQ-036 start pulsed at w_index=4 mid-pass -> ignored; exactly 16 beats and one done.
REQ-037 rst asserted at w_index=9 under backpressure -> next cycle: w_valid=0, busy=0, rom_addr=0; a new start yields index 0 at start+2.
REQ-038 DEPTH=1 -> a single beat with w_index=0, w_last=1, then done.
REQ-039 WFETCH_LOOP_EN defined, loop_cnt=2, w_ready=1 -> 48 gapless beats, w_last only on beat 48, one done pulse.

Source files
------------

// File: rtl/fire_wfetch_pkg.sv
// ---------------------------------------------------------------------------
// fire_wfetch_pkg
//   Shared definitions for the FIRE weight path: the fetch FSM state encoding
//   and the default weight word width / row width that the weight ROM, the
//   fetch block and the MAC array all agree on.
// ---------------------------------------------------------------------------
package fire_wfetch_pkg;

    // Default weight word width (bits) and words per ROM row (one per filter).
    localparam int WFETCH_WIDTH = 16;
    localparam int WFETCH_NUM   = 64;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wfetch_state_e;

endpackage

// File: rtl/fire_weight_fetch.sv
// ---------------------------------------------------------------------------
// fire_weight_fetch
//   Walks a combinational weight ROM row by row and presents each row to the
//   MAC array through a single registered valid/ready stage.  One start
//   request fetches rows 0..DEPTH-1 in order; w_last tags the final row and
//   done pulses one cycle after that row is accepted.
//
// Parameters
//   WIDTH  bits per weight word
//   ADDR   ROM row address width
//   NUM    weight words per ROM row
//   DEPTH  rows per pass (1..2**ADDR)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request a pass (only looked at while idle)
//   loop_cnt          (WFETCH_LOOP_EN only) extra back-to-back passes
//   rom_addr/rom_data row address out, row contents back in the same cycle
//   w_valid/w_ready   handshake for the output row
//   w_data/w_index    registered row and its row number
//   w_last            output row is the final row of the final pass
//   busy              high whenever not idle
//   done              one-cycle completion pulse
//
// Build option
//   `define WFETCH_LOOP_EN adds loop_cnt: the pass is repeated loop_cnt+1
//   times with no bubble between row DEPTH-1 and the next row 0.
// ---------------------------------------------------------------------------
module fire_weight_fetch
    import fire_wfetch_pkg::*;
#(
    parameter int WIDTH = WFETCH_WIDTH,
    parameter int ADDR  = 4,
    parameter int NUM   = WFETCH_NUM,
    parameter int DEPTH = 2**ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef WFETCH_LOOP_EN
    input  logic [7:0]       loop_cnt,
`endif
    output logic [ADDR-1:0]  rom_addr,
    input  logic [WIDTH-1:0] rom_data [0:NUM-1],
    output logic             w_valid,
    input  logic             w_ready,
    output logic [WIDTH-1:0] w_data   [0:NUM-1],
    output logic [ADDR-1:0]  w_index,
    output logic             w_last,
    output logic             busy,
    output logic             done
);

    localparam logic [ADDR-1:0] LAST_ROW = ADDR'(DEPTH - 1);

    wfetch_state_e   state;
    logic [ADDR-1:0] row_cnt;
    logic            load;
    logic            at_last;
    logic            final_pass;

    // The output stage refills whenever it is empty or being drained.
    assign load    = (state == ST_FETCH) && (!w_valid || w_ready);
    assign at_last = (row_cnt == LAST_ROW);

`ifdef WFETCH_LOOP_EN
    // Passes still to run after the current one.
    logic [7:0] pass_left;
    assign final_pass = (pass_left == 8'd0);
`else
    assign final_pass = 1'b1;
`endif

    // The row counter is the ROM address; it only moves on a load, so it is
    // automatically stable while the output stage is stalled.
    assign rom_addr = row_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            row_cnt <= '0;
            w_valid <= 1'b0;
            w_index <= '0;
            w_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                w_data[i] <= '0;
            end
`ifdef WFETCH_LOOP_EN
            pass_left <= 8'd0;
`endif
        end else begin
            done <= 1'b0;

            // Output stage.  A load both replaces the row and keeps w_valid
            // high, so back-to-back rows have no gap.
            if (load) begin
                for (int i = 0; i < NUM; i++) begin
                    w_data[i] <= rom_data[i];
                end
                w_index <= row_cnt;
                w_last  <= at_last && final_pass;
                w_valid <= 1'b1;
            end else if (w_valid && w_ready) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        busy    <= 1'b1;
                        row_cnt <= '0;
`ifdef WFETCH_LOOP_EN
                        pass_left <= loop_cnt;
`endif
                    end
                end

                ST_FETCH: begin
                    if (load) begin
                        if (!at_last) begin
                            row_cnt <= row_cnt + ADDR'(1);
                        end
`ifdef WFETCH_LOOP_EN
                        else if (!final_pass) begin
                            // Wrap straight into the next pass.
                            row_cnt   <= '0;
                            pass_left <= pass_left - 8'd1;
                        end
`endif
                        else begin
                            // Last row captured; counter parks at DEPTH-1.
                            state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Only the final row can be in the stage here.
                    if (w_valid && w_ready) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        row_cnt <= '0;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fire_weight_fetch.sv
// ---------------------------------------------------------------------------
// tb_fire_weight_fetch
//   Self-checking bench for fire_weight_fetch (DEPTH=16 main instance plus a
//   DEPTH=1 instance).  A protocol model runs alongside the main instance the
//   whole time; directed table vectors, hand-written corner sequences and a
//   random phase drive it.
// ---------------------------------------------------------------------------
module tb_fire_weight_fetch;

    localparam int W  = 16;
    localparam int A  = 4;
    localparam int N  = 64;
    localparam int D  = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic         w_ready;
    logic [A-1:0] rom_addr;
    logic [W-1:0] rom_data [0:N-1];
    logic         w_valid;
    logic [W-1:0] w_data   [0:N-1];
    logic [A-1:0] w_index;
    logic         w_last;
    logic         busy;
    logic         done;
`ifdef WFETCH_LOOP_EN
    logic [7:0]   loop_cnt;
`endif

    logic         d1_start;
    logic         d1_ready;
    logic [A-1:0] d1_rom_addr;
    logic [W-1:0] d1_rom_data [0:N-1];
    logic         d1_valid;
    logic [W-1:0] d1_data     [0:N-1];
    logic [A-1:0] d1_index;
    logic         d1_last;
    logic         d1_busy;
    logic         d1_done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    fire_weight_fetch #(.WIDTH(W), .ADDR(A), .NUM(N), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef WFETCH_LOOP_EN
        .loop_cnt(loop_cnt),
`endif
        .rom_addr(rom_addr), .rom_data(rom_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_index(w_index), .w_last(w_last), .busy(busy), .done(done)
    );

    fire_weight_fetch #(.WIDTH(W), .ADDR(A), .NUM(N), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(d1_start),
`ifdef WFETCH_LOOP_EN
        .loop_cnt(8'd0),
`endif
        .rom_addr(d1_rom_addr), .rom_data(d1_rom_data),
        .w_valid(d1_valid), .w_ready(d1_ready), .w_data(d1_data),
        .w_index(d1_index), .w_last(d1_last), .busy(d1_busy), .done(d1_done)
    );

    // ROM image: row k word j = k*64 + j.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            rom_data[j]    = 16'(int'(rom_addr) * 64 + j);
            d1_rom_data[j] = 16'(int'(d1_rom_addr) * 64 + j);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Protocol model: which row should be on the output, whether a pass is in
    // flight, when done is due.  Checked at every falling edge.
    // -----------------------------------------------------------------------
    int          m_idx, m_passes, m_lat;
    bit          m_busy, m_done_due, rst_prev, stall_prev;
    logic [W-1:0] sv_data [0:N-1];
    logic [A-1:0] sv_idx, sv_addr;
    logic         sv_last;

    initial begin
        int bad;
        bit nd, acc;
        m_idx = 0; m_passes = 1; m_lat = 0;
        m_busy = 0; m_done_due = 0; rst_prev = 0; stall_prev = 0;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                chk("rst_w_valid", w_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rom_addr", rom_addr, 0);
                chk("rst_w_last", w_last, 0);
                chk("rst_w_index", w_index, 0);
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done_due);
                if (!m_busy) chk("idle_rom_addr", rom_addr, 0);
                if (m_lat == 1) begin
                    chk("lat1_w_valid", w_valid, 0);
                    chk("lat1_rom_addr", rom_addr, 0);
                end
                if (m_lat == 2) chk("lat2_w_valid", w_valid, 1);
                if (!m_busy || m_done_due) begin
                    chk("w_valid_off", w_valid, 0);
                end else if (w_valid) begin
                    bad = 0;
                    for (int j = 0; j < N; j++)
                        if (w_data[j] !== 16'(m_idx * 64 + j)) bad++;
                    chk("row_index", w_index, m_idx);
                    chk("row_data_bad_words", bad, 0);
                    chk("row_last", w_last, (m_idx == D-1) && (m_passes == 1));
                end
                if (stall_prev) begin
                    bad = 0;
                    for (int j = 0; j < N; j++)
                        if (w_data[j] !== sv_data[j]) bad++;
                    chk("stall_data_changed", bad, 0);
                    chk("stall_index", w_index, sv_idx);
                    chk("stall_last", w_last, sv_last);
                    chk("stall_rom_addr", rom_addr, sv_addr);
                    chk("stall_valid", w_valid, 1);
                end
            end

            stall_prev = !rst && w_valid && !w_ready;
            if (stall_prev) begin
                for (int j = 0; j < N; j++) sv_data[j] = w_data[j];
                sv_idx = w_index; sv_last = w_last; sv_addr = rom_addr;
            end
            if (rst) begin
                m_busy = 0; m_done_due = 0; m_lat = 0; m_idx = 0; m_passes = 1;
            end else begin
                nd = 0;
                if (w_valid && w_ready && m_busy && !m_done_due) begin
                    if (m_idx == D-1) begin
                        m_idx = 0;
                        if (m_passes == 1) nd = 1;
                        else m_passes--;
                    end else begin
                        m_idx++;
                    end
                end
                acc = !m_busy && start;
                if (m_done_due) m_busy = 0;
                m_done_due = nd;
                if (acc) begin
                    m_busy = 1; m_idx = 0; m_lat = 1;
`ifdef WFETCH_LOOP_EN
                    m_passes = int'(loop_cnt) + 1;
`else
                    m_passes = 1;
`endif
                end else if (m_lat == 1 || m_lat == 2) begin
                    m_lat++;
                end else begin
                    m_lat = 0;
                end
            end
            rst_prev = rst;
        end
    end

    // -----------------------------------------------------------------------
    // Directed table: stall window, stray start, expected beats/done time.
    // exp_done_t counts cycles from the start cycle to the done cycle:
    // 2 cycles latency + 16 rows + stall cycles.
    // -----------------------------------------------------------------------
    typedef struct {
        int stall_at;
        int stall_len;
        int start_at;
        int exp_beats;
        int exp_done_t;
    } vec_t;

    vec_t vecs [6];

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; d1_start = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic run_pass(input vec_t v, output int beats, output int dones, output int t_done);
        int t0, left;
        bit pulsed, saw3;
        beats = 0; dones = 0; t_done = -1; left = v.stall_len; pulsed = 0; saw3 = 0;
        w_ready = 1'b1;
        start = 1'b1;
        t0 = cyc_cnt;
        cyc();
        start = 1'b0;
        for (int g = 0; g < 200 && t_done < 0; g++) begin
            if (w_valid && int'(w_index) == v.stall_at && left > 0) begin
                w_ready = 1'b0; left--;
            end else begin
                w_ready = 1'b1;
            end
            if (w_valid && int'(w_index) == v.start_at && !pulsed) begin
                start = 1'b1; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (w_valid && w_index == 4'd3 && !saw3) begin
                saw3 = 1;
                chk("w_data5_at_index3", w_data[5], 197);
            end
            if (w_valid && w_ready) beats++;
            cyc();
            if (done) begin dones++; t_done = cyc_cnt - t0; end
        end
        start = 1'b0;
        repeat (3) begin
            cyc();
            if (done) dones++;
        end
    endtask

    initial begin
        int beats, dones, t_done, first, lastb, nlast, last_no, b1, bcyc;
        rst = 1'b1; start = 1'b0; w_ready = 1'b0;
        d1_start = 1'b0; d1_ready = 1'b0;
`ifdef WFETCH_LOOP_EN
        loop_cnt = 8'd0;
`endif
        vecs[0] = '{-1, 0, -1, 16, 18};
        vecs[1] = '{ 7, 3, -1, 16, 21};
        vecs[2] = '{-1, 0,  4, 16, 18};
        vecs[3] = '{ 0, 1, -1, 16, 19};
        vecs[4] = '{15, 2, 15, 16, 20};
        vecs[5] = '{ 3, 5,  9, 16, 23};

        // Reset state.
        do_reset();
        chk("rst_w_data10", w_data[10], 0);
        chk("rst_d1_valid", d1_valid, 0);

        // Table-driven passes.
        foreach (vecs[i]) begin
            run_pass(vecs[i], beats, dones, t_done);
            chk($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
            chk($sformatf("vec%0d_dones", i), dones, 1);
            chk($sformatf("vec%0d_done_time", i), t_done, vecs[i].exp_done_t);
        end

        // Reset mid-pass under backpressure, then restart straight away.
        w_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        for (int g = 0; g < 40 && !(w_valid && w_index == 4'd9); g++) cyc();
        chk("reach_index9", w_index, 9);
        w_ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_w_valid", w_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_w_data5", w_data[5], 0);
        rst = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_n1_valid", w_valid, 0);
        cyc();
        chk("restart_n2_valid", w_valid, 1);
        chk("restart_n2_index", w_index, 0);
        w_ready = 1'b1;
        t_done = -1;
        for (int g = 0; g < 40 && t_done < 0; g++) begin
            cyc();
            if (done) t_done = g;
        end
        chk("restart_done_seen", t_done >= 0, 1);
        cyc(); cyc();

        // DEPTH=1 instance.
        b1 = 0; bcyc = -1; dones = 0;
        d1_ready = 1'b1;
        d1_start = 1'b1; cyc(); d1_start = 1'b0;
        chk("d1_busy", d1_busy, 1);
        for (int g = 0; g < 10; g++) begin
            if (d1_valid && d1_ready) begin
                b1++; bcyc = cyc_cnt;
                chk("d1_index", d1_index, 0);
                chk("d1_last", d1_last, 1);
                chk("d1_data7", d1_data[7], 7);
            end
            cyc();
            if (d1_done) begin
                dones++;
                chk("d1_done_delay", cyc_cnt - bcyc, 1);
            end
        end
        chk("d1_beats", b1, 1);
        chk("d1_dones", dones, 1);

`ifdef WFETCH_LOOP_EN
        // Three gapless passes.
        loop_cnt = 8'd2; w_ready = 1'b1;
        beats = 0; dones = 0; first = -1; lastb = -1; nlast = 0; last_no = 0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int g = 0; g < 150; g++) begin
            if (w_valid && w_ready) begin
                beats++;
                if (first < 0) first = cyc_cnt;
                lastb = cyc_cnt;
                if (w_last) begin nlast++; last_no = beats; end
            end
            cyc();
            if (done) dones++;
        end
        chk("loop_beats", beats, 48);
        chk("loop_gapless_span", lastb - first, 47);
        chk("loop_last_count", nlast, 1);
        chk("loop_last_beat_no", last_no, 48);
        chk("loop_dones", dones, 1);
        loop_cnt = 8'd0;
`else
        first = 0; lastb = 0; nlast = 0; last_no = 0;
`endif

        // Random phase: ready jitter, stray starts, occasional reset.
        for (int g = 0; g < 3000; g++) begin
            w_ready = ($urandom_range(0, 3) != 0);
            start   = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 249) == 0);
`ifdef WFETCH_LOOP_EN
            if (!busy) loop_cnt = 8'($urandom_range(0, 2));
`endif
            cyc();
        end
        rst = 1'b0; start = 1'b0; w_ready = 1'b1;
        repeat (80) cyc();
        chk("final_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
